// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: one-outstanding req/ack fetch from instruction memory into a
// small {pc, instr} FIFO, presented to the datapath over valid/ready, flushed on redirect.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         dp_valid,
  input  logic                         dp_ready,
  output logic [31:0]                  dp_instr,
  output logic [31:0]                  dp_pc,
  output logic [31:0]                  dp_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_req_addr;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];

  state_t          w_state_nxt;
  logic [31:0]     w_fetch_pc_nxt;
  logic [31:0]     w_req_addr_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_not_empty;
  logic [31:0]     w_redirect_pc;
  logic [31:0]     w_fetch_pc_inc;
  logic [CW-1:0]   w_count_post;

  assign w_redirect_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
  assign w_not_empty    = (r_count != CW'(0));
  assign w_pop          = w_not_empty & dp_ready;
  // Count as it will be after this cycle's push, used to decide whether to keep streaming.
  assign w_count_post   = r_count + CW'(1) - CW'(w_pop);

  // Fetch FSM next-state and fetch-address decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_flush        = 1'b1;
        end else if (r_count < DEPTH_C) begin
          w_req_addr_nxt = r_fetch_pc;
          w_state_nxt    = ST_FETCH;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            w_fetch_pc_nxt = w_redirect_pc;
            w_flush        = 1'b1;
            w_state_nxt    = ST_IDLE;
          end else begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = w_fetch_pc_inc;
            if (w_count_post < DEPTH_C) begin
              w_req_addr_nxt = w_fetch_pc_inc;
            end else begin
              w_state_nxt    = ST_IDLE;
            end
          end
        end else begin
          if (redirect) begin
            w_fetch_pc_nxt = w_redirect_pc;
            w_flush        = 1'b1;
            w_state_nxt    = ST_DISCARD;
          end else begin
            w_state_nxt    = ST_FETCH;
          end
        end
      end
      ST_DISCARD: begin
        // The stale request stays on the bus until memory acks it; its data is dropped.
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_flush        = 1'b1;
        end else begin
          w_fetch_pc_nxt = r_fetch_pc;
        end
        if (imem_ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_flush     = 1'b1;
      end
    endcase
  end

  // FSM state and fetch address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // Queue pointers and count; a flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= PW'(0);
      r_tail  <= PW'(0);
      r_count <= CW'(0);
    end else if (w_flush) begin
      r_head  <= PW'(0);
      r_tail  <= PW'(0);
      r_count <= CW'(0);
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage written at the tail on push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= 32'd0;
        r_mem_instr[i] <= 32'd0;
      end
    end else if (w_push && !w_flush) begin
      r_mem_pc[r_tail]    <= r_req_addr;
      r_mem_instr[r_tail] <= imem_rdata;
    end
  end

  assign imem_req    = (r_state != ST_IDLE);
  assign imem_addr   = r_req_addr;
  assign occupancy   = r_count;
  assign dp_valid    = w_not_empty;
  // Empty queue presents a nop at pc 0 rather than stale storage.
  assign dp_instr    = w_not_empty ? r_mem_instr[r_head]        : 32'd0;
  assign dp_pc       = w_not_empty ? r_mem_pc[r_head]           : 32'd0;
  assign dp_pc_plus4 = w_not_empty ? (r_mem_pc[r_head] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a small memory model with programmable latency
// answers fetches with data = ~address; all expected values are written out per cycle.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dp_valid;
  logic        dp_ready;
  logic [31:0] dp_instr;
  logic [31:0] dp_pc;
  logic [31:0] dp_pc_plus4;
  logic [2:0]  occupancy;

  int n_vec;
  int n_miss;
  int mem_lat;
  logic mem_hold;
  int wait_cnt;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dp_valid    (dp_valid),
    .dp_ready    (dp_ready),
    .dp_instr    (dp_instr),
    .dp_pc       (dp_pc),
    .dp_pc_plus4 (dp_pc_plus4),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after mem_lat wait cycles, updated just after each falling edge.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req && !mem_hold) begin
        if (wait_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = ~imem_addr;
          wait_cnt   = 0;
        end else begin
          imem_ack   = 1'b0;
          wait_cnt   = wait_cnt + 1;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rst         = 1'b0;
    dp_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    mem_lat     = 0;
    mem_hold    = 1'b0;

    step(2);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr,         32'h0000_0000);
    chk("rst_valid", {31'd0, dp_valid}, 32'd0);
    chk("rst_instr", dp_instr,          32'd0);
    chk("rst_pc",    dp_pc,             32'd0);
    chk("rst_pc4",   dp_pc_plus4,       32'd0);
    chk("rst_occ",   {29'd0, occupancy}, 32'd0);

    // Streaming: zero-wait memory, datapath always ready.
    dp_ready = 1'b1;
    rst      = 1'b1;
    step(1);
    chk("c1_req",   {31'd0, imem_req}, 32'd1);
    chk("c1_addr",  imem_addr,         32'h0000_0000);
    chk("c1_valid", {31'd0, dp_valid}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("str_valid", {31'd0, dp_valid}, 32'd1);
      chk("str_pc",    dp_pc,             32'(4 * k));
      chk("str_instr", dp_instr,          ~32'(4 * k));
      chk("str_pc4",   dp_pc_plus4,       32'(4 * k + 4));
      chk("str_addr",  imem_addr,         32'(4 * k + 4));
    end

    // Stall the datapath: queue fills to 4 and fetching stops.
    dp_ready = 1'b0;
    step(3);
    chk("full_occ", {29'd0, occupancy}, 32'd4);
    chk("full_req", {31'd0, imem_req},  32'd0);
    chk("full_pc",  dp_pc,              32'h0000_0014);
    step(2);
    chk("hold_occ", {29'd0, occupancy}, 32'd4);
    chk("hold_req", {31'd0, imem_req},  32'd0);
    dp_ready = 1'b1;
    step(1);
    dp_ready = 1'b0;
    chk("pop_occ", {29'd0, occupancy}, 32'd3);
    chk("pop_pc",  dp_pc,              32'h0000_0018);
    chk("pop_req", {31'd0, imem_req},  32'd0);
    step(1);
    chk("refill_req",  {31'd0, imem_req}, 32'd1);
    chk("refill_addr", imem_addr,         32'h0000_0024);
    step(1);
    chk("refill_occ", {29'd0, occupancy}, 32'd4);
    chk("refill_idle", {31'd0, imem_req}, 32'd0);

    // Redirect while a slow fetch is outstanding: request held until the stale ack.
    mem_lat  = 3;
    dp_ready = 1'b1;
    step(1);
    dp_ready = 1'b0;
    step(1);
    chk("slow_req",  {31'd0, imem_req}, 32'd1);
    chk("slow_addr", imem_addr,         32'h0000_0028);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step(1);
    redirect = 1'b0;
    chk("disc_valid", {31'd0, dp_valid}, 32'd0);
    chk("disc_occ",   {29'd0, occupancy}, 32'd0);
    chk("disc_req",   {31'd0, imem_req},  32'd1);
    chk("disc_addr",  imem_addr,          32'h0000_0028);
    chk("disc_instr", dp_instr,           32'd0);
    step(1);
    chk("disc_addr2", imem_addr,          32'h0000_0028);
    step(2);
    chk("stale_valid", {31'd0, dp_valid}, 32'd0);
    chk("stale_req",   {31'd0, imem_req}, 32'd0);
    mem_lat = 0;
    step(1);
    chk("redir_req",  {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr,         32'h0000_0100);
    step(1);
    chk("redir_valid", {31'd0, dp_valid}, 32'd1);
    chk("redir_pc",    dp_pc,             32'h0000_0100);
    chk("redir_instr", dp_instr,          32'hFFFF_FEFF);

    // Redirect colliding with an ack and a pop at occupancy 2; low pc bits dropped.
    step(1);
    chk("coll_occ", {29'd0, occupancy}, 32'd2);
    dp_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    step(1);
    redirect = 1'b0;
    chk("coll_occ0",  {29'd0, occupancy}, 32'd0);
    chk("coll_valid", {31'd0, dp_valid},  32'd0);
    chk("coll_req",   {31'd0, imem_req},  32'd0);
    step(1);
    chk("align_addr", imem_addr, 32'h0000_0200);
    step(1);
    chk("align_pc",    dp_pc,    32'h0000_0200);
    chk("align_instr", dp_instr, 32'hFFFF_FDFF);

    // Fetch address wraps past the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    step(1);
    chk("wrap_pc0",   dp_pc,       32'hFFFF_FFF8);
    chk("wrap_pc40",  dp_pc_plus4, 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_addr,   32'hFFFF_FFFC);
    step(1);
    chk("wrap_pc1",   dp_pc,       32'hFFFF_FFFC);
    chk("wrap_pc41",  dp_pc_plus4, 32'h0000_0000);
    chk("wrap_ins1",  dp_instr,    32'h0000_0003);
    chk("wrap_addr2", imem_addr,   32'h0000_0000);

    // Asynchronous reset mid-fetch with three entries queued.
    dp_ready = 1'b0;
    step(2);
    mem_hold = 1'b1;
    chk("pre_occ",  {29'd0, occupancy}, 32'd3);
    chk("pre_req",  {31'd0, imem_req},  32'd1);
    chk("pre_addr", imem_addr,          32'h0000_0008);
    rst = 1'b0;
    #2;
    chk("arst_req",   {31'd0, imem_req},  32'd0);
    chk("arst_addr",  imem_addr,          32'h0000_0000);
    chk("arst_valid", {31'd0, dp_valid},  32'd0);
    chk("arst_occ",   {29'd0, occupancy}, 32'd0);
    chk("arst_pc",    dp_pc,              32'd0);
    chk("arst_pc4",   dp_pc_plus4,        32'd0);
    step(1);
    chk("arst_hold", {31'd0, imem_req}, 32'd0);
    mem_hold = 1'b0;
    rst      = 1'b1;
    step(1);
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr,         32'h0000_0000);
    step(1);
    chk("rel_valid", {31'd0, dp_valid},  32'd1);
    chk("rel_pc",    dp_pc,              32'h0000_0000);
    chk("rel_occ",   {29'd0, occupancy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
